// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the i2c_target_unit I2C target.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEVADDR,
    WORDADDR,
    WRDATA,
    RDDATA
  } i2cTargetState_t;

  localparam int unsigned BIT_CNT_W = 4;

  // Bit counter values: 7 = last data bit, 8 = ACK slot, 9 = ACK clock high
  localparam logic [BIT_CNT_W-1:0] CNT_BIT7    = BIT_CNT_W'(7);
  localparam logic [BIT_CNT_W-1:0] CNT_ACK     = BIT_CNT_W'(8);
  localparam logic [BIT_CNT_W-1:0] CNT_ACKHIGH = BIT_CNT_W'(9);

endpackage

// File: rtl/i2c_input_filter.sv
// Two-flop synchronizer with an optional stability filter (macro I2C_TARGET_FILTER_EN).
module i2c_input_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Idle bus level is high, so reset to 1 to avoid a spurious edge on release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[0], d_i};
  end

`ifdef I2C_TARGET_FILTER_EN
  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (32'(cnt_q) + 32'd1 >= FILTER_LEN) filt_d = sync_q[1];
      else                                  cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign q_o = filt_q;
`else
  logic unusedFilterLen;
  assign unusedFilterLen = ^FILTER_LEN;
  assign q_o = sync_q[1];
`endif

endmodule

// File: rtl/i2c_target_unit.sv
// I2C target with EEPROM-style pointer/data protocol onto a 256-byte strobe register port.
// Optional input glitch filter: define I2C_TARGET_FILTER_EN.
module i2c_target_unit
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = 7'h50,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2cScl,
  inout  wire        i2cSda,
  output logic [7:0] regAddr,
  output logic [7:0] regWriteData,
  output logic       regWrite,
  output logic       regRead,
  input  logic [7:0] regReadData,
  output logic       busy
);

  logic sclS, sdaS;
  logic sclPrev_q, sdaPrev_q;
  logic sclRise, sclFall, startDet, stopDet;

  i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_sclFilter (
    .clk   (clk),
    .reset (reset),
    .d_i   (i2cScl),
    .q_o   (sclS)
  );

  i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_sdaFilter (
    .clk   (clk),
    .reset (reset),
    .d_i   (i2cSda),
    .q_o   (sdaS)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclPrev_q <= sclS;
      sdaPrev_q <= sdaS;
    end
  end

  assign sclRise  =  sclS & ~sclPrev_q;
  assign sclFall  = ~sclS &  sclPrev_q;
  assign startDet =  sclS &  sclPrev_q &  sdaPrev_q & ~sdaS;
  assign stopDet  =  sclS &  sclPrev_q & ~sdaPrev_q &  sdaS;

  i2cTargetState_t        state_q, state_d;
  logic [BIT_CNT_W-1:0]   bitCnt_q, bitCnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             regAddr_q, regAddr_d;
  logic [7:0]             regWriteData_q, regWriteData_d;
  logic                   regWrite_q, regWrite_d;
  logic                   regRead_q, regRead_d;
  logic                   sdaLow_q, sdaLow_d;
  logic                   busy_q, busy_d;
  logic                   rw_q, rw_d;
  logic [7:0]             rxByte;

  assign rxByte = {shift_q[6:0], sdaS};

  always_comb begin
    state_d        = state_q;
    bitCnt_d       = bitCnt_q;
    shift_d        = shift_q;
    regAddr_d      = regAddr_q;
    regWriteData_d = regWriteData_q;
    regWrite_d     = 1'b0;
    regRead_d      = 1'b0;
    sdaLow_d       = sdaLow_q;
    busy_d         = busy_q;
    rw_d           = rw_q;

    // Pointer advances the cycle after a write strobe; read data lands the cycle after a read strobe
    if (regWrite_q) regAddr_d = regAddr_q + 8'd1;
    if (regRead_q)  shift_d   = regReadData;

    if (stopDet) begin
      state_d  = IDLE;
      bitCnt_d = '0;
      sdaLow_d = 1'b0;
      busy_d   = 1'b0;
    end else if (startDet) begin
      state_d  = DEVADDR;
      bitCnt_d = '0;
      sdaLow_d = 1'b0;
    end else if (state_q != IDLE) begin
      if (sclRise) begin
        if (bitCnt_q < CNT_ACK) begin
          bitCnt_d = bitCnt_q + BIT_CNT_W'(1);
          if (state_q != RDDATA) shift_d = rxByte;
          if (bitCnt_q == CNT_BIT7) begin
            case (state_q)
              DEVADDR: begin
                if (rxByte[7:1] != DEV_ADDR) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                end else begin
                  busy_d = 1'b1;
                  rw_d   = rxByte[0];
                end
              end
              WORDADDR: regAddr_d = rxByte;
              WRDATA: begin
                regWriteData_d = rxByte;
                regWrite_d     = 1'b1;
              end
              default: ;
            endcase
          end
        end else if (bitCnt_q == CNT_ACK) begin
          bitCnt_d = CNT_ACKHIGH;
          if (state_q == RDDATA) begin
            if (sdaS) begin
              state_d  = IDLE;
              sdaLow_d = 1'b0;
            end else begin
              regAddr_d = regAddr_q + 8'd1;
              regRead_d = 1'b1;
            end
          end
        end
      end else if (sclFall) begin
        if (bitCnt_q == CNT_ACK) begin
          if (state_q == RDDATA) begin
            sdaLow_d = 1'b0;
          end else begin
            sdaLow_d = 1'b1;
            if (state_q == DEVADDR && rw_q) regRead_d = 1'b1;
          end
        end else if (bitCnt_q == CNT_ACKHIGH) begin
          bitCnt_d = '0;
          case (state_q)
            DEVADDR:  state_d = rw_q ? RDDATA : WORDADDR;
            WORDADDR: state_d = WRDATA;
            default:  ;
          endcase
          // Entering or continuing a read: present the MSB on the same fall that ends the ACK
          if (state_q == RDDATA || (state_q == DEVADDR && rw_q)) sdaLow_d = ~shift_q[7];
          else                                                   sdaLow_d = 1'b0;
        end else if (state_q == RDDATA && bitCnt_q != '0) begin
          shift_d  = {shift_q[6:0], 1'b0};
          sdaLow_d = ~shift_q[6];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      bitCnt_q       <= '0;
      shift_q        <= '0;
      regAddr_q      <= '0;
      regWriteData_q <= '0;
      regWrite_q     <= 1'b0;
      regRead_q      <= 1'b0;
      sdaLow_q       <= 1'b0;
      busy_q         <= 1'b0;
      rw_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      bitCnt_q       <= bitCnt_d;
      shift_q        <= shift_d;
      regAddr_q      <= regAddr_d;
      regWriteData_q <= regWriteData_d;
      regWrite_q     <= regWrite_d;
      regRead_q      <= regRead_d;
      sdaLow_q       <= sdaLow_d;
      busy_q         <= busy_d;
      rw_q           <= rw_d;
    end
  end

  assign i2cSda       = sdaLow_q ? 1'b0 : 1'bz;
  assign regAddr      = regAddr_q;
  assign regWriteData = regWriteData_q;
  assign regWrite     = regWrite_q;
  assign regRead      = regRead_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_target_unit.sv
// Directed bench for i2c_target_unit: bus controller tasks plus a strobe scoreboard.
module tb_i2c_target_unit;

  localparam int Q = 100;  // quarter SCL period; clk period is 10

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       scl_r;
  logic       sda_low_r;
  wire        sda;
  logic [7:0] regAddr, regWriteData, regReadData;
  logic       regWrite, regRead, busy;

  pullup (sda);
  assign sda = sda_low_r ? 1'b0 : 1'bz;

  i2c_target_unit #(.DEV_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .i2cScl       (scl_r),
    .i2cSda       (sda),
    .regAddr      (regAddr),
    .regWriteData (regWriteData),
    .regWrite     (regWrite),
    .regRead      (regRead),
    .regReadData  (regReadData),
    .busy         (busy)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] wq[$];     // expected {addr, data} per regWrite
  logic [7:0]  rq[$];     // expected addr per regRead
  logic [7:0]  exp_mem [256];

  // Register-space peripheral model
  logic [7:0] mem [256];
  assign regReadData = mem[regAddr];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (regWrite) begin
      mem[regAddr] <= regWriteData;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe scoreboard
  always @(negedge clk) begin
    logic [15:0] ew;
    logic [7:0]  ea;
    if (rst_n) begin
      if (regWrite || regRead) chk("strobe_exclusive", 16'(regWrite & regRead), 16'h0);
      if (regWrite) begin
        ew = (wq.size() != 0) ? wq.pop_front() : 16'hxxxx;
        chk("regWrite_addr_data", {regAddr, regWriteData}, ew);
      end
      if (regRead) begin
        ea = (rq.size() != 0) ? rq.pop_front() : 8'hxx;
        chk("regRead_addr", 16'(regAddr), 16'(ea));
      end
    end
  end

  task automatic bus_start();
    sda_low_r = 1'b0; #Q;
    scl_r     = 1'b1; #Q;
    sda_low_r = 1'b1; #Q;
    scl_r     = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_low_r = 1'b1; #Q;
    scl_r     = 1'b1; #Q;
    sda_low_r = 1'b0; #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_low_r = ~b; #Q;
    scl_r     = 1'b1; #(2*Q);
    scl_r     = 1'b0; #Q;
  endtask

  task automatic write_bit_glitch();
    sda_low_r = 1'b0; #Q;
    scl_r     = 1'b1; #(Q/2);
    sda_low_r = 1'b1; #20;
    sda_low_r = 1'b0; #(Q + Q/2 - 20);
    scl_r     = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_low_r = 1'b0; #Q;
    scl_r     = 1'b1; #Q;
    b         = sda;  #Q;
    scl_r     = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack_n);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  initial begin
    logic       ack_n;
    logic [7:0] rd;
    logic [7:0] ctl;

    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h5A;
    rst_n = 1'b0; scl_r = 1'b1; sda_low_r = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_regAddr", 16'(regAddr), 16'h0);
    chk("rst_regWriteData", 16'(regWriteData), 16'h0);
    chk("rst_regWrite", 16'(regWrite), 16'h0);
    chk("rst_regRead", 16'(regRead), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_sda", 16'(sda), 16'h1);
    @(negedge clk); rst_n = 1'b1;
    #(4*Q);

    // 1: single write at 0x05
    bus_start();
    write_byte(8'hA0, ack_n); chk("t1_ctl_ack", 16'(ack_n), 16'h0);
    chk("t1_busy", 16'(busy), 16'h1);
    write_byte(8'h05, ack_n); chk("t1_ptr_ack", 16'(ack_n), 16'h0);
    wq.push_back({8'h05, 8'h3C}); exp_mem[8'h05] = 8'h3C;
    write_byte(8'h3C, ack_n); chk("t1_data_ack", 16'(ack_n), 16'h0);
    bus_stop(); #Q;
    chk("t1_regAddr_end", 16'(regAddr), 16'h06);
    chk("t1_busy_after_stop", 16'(busy), 16'h0);
    chk("t1_writes_done", 16'(wq.size()), 16'h0);

    // 2: random read of 0x05
    bus_start();
    write_byte(8'hA0, ack_n); chk("t2_ctl_ack", 16'(ack_n), 16'h0);
    write_byte(8'h05, ack_n); chk("t2_ptr_ack", 16'(ack_n), 16'h0);
    bus_start();
    rq.push_back(8'h05);
    write_byte(8'hA1, ack_n); chk("t2_rd_ctl_ack", 16'(ack_n), 16'h0);
    read_byte(1'b1, rd); chk("t2_byte", 16'(rd), 16'(exp_mem[8'h05]));
    chk("t2_busy_after_nack", 16'(busy), 16'h1);
    bus_stop(); #Q;
    chk("t2_reads_done", 16'(rq.size()), 16'h0);
    chk("t2_regAddr_end", 16'(regAddr), 16'h05);

    // 3: wrong device address
    bus_start();
    write_byte(8'hA2, ack_n); chk("t3_no_ack", 16'(ack_n), 16'h1);
    chk("t3_busy", 16'(busy), 16'h0);
    bus_stop(); #Q;

    // 4: pointer wrap on write
    bus_start();
    write_byte(8'hA0, ack_n); chk("t4_ctl_ack", 16'(ack_n), 16'h0);
    write_byte(8'hFF, ack_n); chk("t4_ptr_ack", 16'(ack_n), 16'h0);
    wq.push_back({8'hFF, 8'h11}); exp_mem[8'hFF] = 8'h11;
    write_byte(8'h11, ack_n); chk("t4_d0_ack", 16'(ack_n), 16'h0);
    wq.push_back({8'h00, 8'h22}); exp_mem[8'h00] = 8'h22;
    write_byte(8'h22, ack_n); chk("t4_d1_ack", 16'(ack_n), 16'h0);
    bus_stop(); #Q;
    chk("t4_regAddr_end", 16'(regAddr), 16'h01);
    chk("t4_writes_done", 16'(wq.size()), 16'h0);

    // 5: sequential read across the wrap
    bus_start();
    write_byte(8'hA0, ack_n); chk("t5_ctl_ack", 16'(ack_n), 16'h0);
    write_byte(8'hFE, ack_n); chk("t5_ptr_ack", 16'(ack_n), 16'h0);
    bus_start();
    rq.push_back(8'hFE);
    write_byte(8'hA1, ack_n); chk("t5_rd_ctl_ack", 16'(ack_n), 16'h0);
    rq.push_back(8'hFF);
    read_byte(1'b0, rd); chk("t5_byte_FE", 16'(rd), 16'(exp_mem[8'hFE]));
    rq.push_back(8'h00);
    read_byte(1'b0, rd); chk("t5_byte_FF", 16'(rd), 16'(exp_mem[8'hFF]));
    read_byte(1'b1, rd); chk("t5_byte_00", 16'(rd), 16'(exp_mem[8'h00]));
    bus_stop(); #Q;
    chk("t5_reads_done", 16'(rq.size()), 16'h0);
    chk("t5_regAddr_end", 16'(regAddr), 16'h00);

    // 6: STOP after four data bits aborts the byte
    bus_start();
    write_byte(8'hA0, ack_n); chk("t6_ctl_ack", 16'(ack_n), 16'h0);
    write_byte(8'h10, ack_n); chk("t6_ptr_ack", 16'(ack_n), 16'h0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    bus_stop(); #Q;
    chk("t6_sda_released", 16'(sda), 16'h1);
    chk("t6_busy", 16'(busy), 16'h0);
    chk("t6_regAddr", 16'(regAddr), 16'h10);

`ifdef I2C_TARGET_FILTER_EN
    // 6b: short SDA glitch while SCL high is neither START nor STOP
    bus_start();
    write_byte(8'hA0, ack_n); chk("t6g_ctl_ack", 16'(ack_n), 16'h0);
    write_byte(8'h30, ack_n); chk("t6g_ptr_ack", 16'(ack_n), 16'h0);
    wq.push_back({8'h30, 8'hFF}); exp_mem[8'h30] = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) write_bit_glitch();
      else        write_bit(1'b1);
    end
    read_bit(ack_n); chk("t6g_data_ack", 16'(ack_n), 16'h0);
    bus_stop(); #Q;
    chk("t6g_writes_done", 16'(wq.size()), 16'h0);
    chk("t6g_regAddr_end", 16'(regAddr), 16'h31);
`endif

    // 7: asynchronous reset during the ACK drive releases SDA
    bus_start();
    ctl = 8'hA0;
    for (int i = 7; i >= 0; i--) write_bit(ctl[i]);
    sda_low_r = 1'b0; #1;
    chk("t7_ack_driven", 16'(sda), 16'h0);
    rst_n = 1'b0; #1;
    chk("t7_sda_after_reset", 16'(sda), 16'h1);
    chk("t7_busy_after_reset", 16'(busy), 16'h0);
    #Q;
    @(negedge clk); rst_n = 1'b1;
    bus_stop(); #(2*Q);
    chk("t7_final_writes", 16'(wq.size()), 16'h0);
    chk("t7_final_reads", 16'(rq.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
